// File: rtl/tlp_tx_arbiter_pkg.sv
// Shared types and widths for the TLP transmit arbiter slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: arbiter FSM state type, request-source type, header and PIPE
// beat widths, and a helper that returns the opposite source.
package tlp_tx_arbiter_pkg;

    // One 4DW TLP header per header-FIFO entry.
    localparam int TLP_HDR_WIDTH   = 128;

    // Beat width of the PIPE-side datapath; must be >= TLP_HDR_WIDTH so a
    // header fits in a single beat.
    localparam int PIPE_DATA_WIDTH = 256;

    typedef enum logic [1:0] {
        IDLE,
        WR_HDR,
        WR_DATA,
        RD_HDR
    } tlp_arb_state_t;

    typedef enum logic {
        SRC_WR,
        SRC_RD
    } tlp_src_t;

    function automatic tlp_src_t other_src(input tlp_src_t src);
        return (src == SRC_WR) ? SRC_RD : SRC_WR;
    endfunction

endpackage

// File: rtl/tlp_tx_arbiter_if.sv
// Bundles the three staging-FIFO read ports and the outgoing TLP beat stream.
// Latency: n/a (wiring only).
// Backpressure: tlp_ready_i from the framing stage throttles every FIFO pop.
//
// Modports:
//   master - the arbiter: reads FIFO heads, drives rden and the beat stream.
//   slave  - the FIFO/framing side: drives FIFO heads and tlp_ready_i.
interface tlp_tx_arbiter_if #(
    parameter int HDR_WIDTH  = tlp_tx_arbiter_pkg::TLP_HDR_WIDTH,
    parameter int DATA_WIDTH = tlp_tx_arbiter_pkg::PIPE_DATA_WIDTH
);

    // AW (memory-write) header FIFO, show-ahead
    logic                  aw_empty_i;
    logic [HDR_WIDTH-1:0]  aw_rdata_i;
    logic                  aw_rden_o;

    // AR (memory-read) header FIFO, show-ahead
    logic                  ar_empty_i;
    logic [HDR_WIDTH-1:0]  ar_rdata_i;
    logic                  ar_rden_o;

    // Write payload FIFO, show-ahead, with end-of-TLP marker
    logic                  pw_empty_i;
    logic [DATA_WIDTH-1:0] pw_rdata_i;
    logic                  pw_last_i;
    logic                  pw_rden_o;

    // Outgoing TLP beat stream (valid/ready)
    logic                  tlp_valid_o;
    logic                  tlp_ready_i;
    logic [DATA_WIDTH-1:0] tlp_data_o;
    logic                  tlp_sop_o;
    logic                  tlp_eop_o;
    logic                  tlp_is_wr_o;

    modport master (
        input  aw_empty_i, aw_rdata_i,
        output aw_rden_o,
        input  ar_empty_i, ar_rdata_i,
        output ar_rden_o,
        input  pw_empty_i, pw_rdata_i, pw_last_i,
        output pw_rden_o,
        output tlp_valid_o, tlp_data_o, tlp_sop_o, tlp_eop_o, tlp_is_wr_o,
        input  tlp_ready_i
    );

    modport slave (
        output aw_empty_i, aw_rdata_i,
        input  aw_rden_o,
        output ar_empty_i, ar_rdata_i,
        input  ar_rden_o,
        output pw_empty_i, pw_rdata_i, pw_last_i,
        input  pw_rden_o,
        input  tlp_valid_o, tlp_data_o, tlp_sop_o, tlp_eop_o, tlp_is_wr_o,
        output tlp_ready_i
    );

endinterface

// File: rtl/tlp_tx_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter (write vs read) with a last-grant register.
// Latency: grant is combinational from the requests; last-grant updates next edge.
// Backpressure: last-grant only advances when grant_en is high and a grant is made.
//
// Ports:
//   clk, rst      - clock, synchronous active-high reset (last grant -> SRC_RD)
//   req_wr/req_rd - request lines
//   grant_en      - commit the current grant into the last-grant register
//   gnt_vld       - at least one requester is active
//   gnt_src       - winning source (only meaningful with gnt_vld)
module tlp_tx_arbiter_rr_arb2
    import tlp_tx_arbiter_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     req_wr,
    input  logic     req_rd,
    input  logic     grant_en,
    output logic     gnt_vld,
    output tlp_src_t gnt_src
);

    tlp_src_t last_q;

    always_comb begin
        gnt_vld = req_wr || req_rd;
        gnt_src = SRC_WR;
        if (req_wr && req_rd) begin
            // Contention: the side that did not win last time goes next.
            gnt_src = other_src(last_q);
        end else if (req_rd) begin
            gnt_src = SRC_RD;
        end
    end

    // Resetting to SRC_RD makes a write win the first tie after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= SRC_RD;
        end else if (grant_en && gnt_vld) begin
            last_q <= gnt_src;
        end
    end

endmodule

// File: rtl/tlp_tx_arbiter.sv
// Merges AW header, AR header and write-payload FIFOs into one TLP beat stream.
// Latency: one idle bubble per TLP for arbitration, then one beat per cycle.
// Backpressure: beats hold stable and no FIFO is popped while tlp_ready_i is low.
//
// Ports:
//   clk, rst - clock and synchronous active-high reset
//   bus      - tlp_tx_arbiter_if.master: three show-ahead FIFO read ports
//              (empty/rdata/rden, plus pw_last_i) and the valid/ready beat
//              stream (data/sop/eop/is_wr)
//   wr_tlp_cnt_o, rd_tlp_cnt_o, stall_cnt_o - 32-bit wrapping statistics,
//              present only when TLP_ARB_STATS_EN is defined
//
// Write TLPs are a header beat followed by payload beats up to pw_last_i; read
// TLPs are a single header beat. Beats of different TLPs never interleave.
// DATA_WIDTH must be >= HDR_WIDTH; headers are zero-extended into a beat.
module tlp_tx_arbiter
    import tlp_tx_arbiter_pkg::*;
#(
    parameter int HDR_WIDTH  = TLP_HDR_WIDTH,
    parameter int DATA_WIDTH = PIPE_DATA_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    tlp_tx_arbiter_if.master   bus
`ifdef TLP_ARB_STATS_EN
    ,
    output logic [31:0]        wr_tlp_cnt_o,
    output logic [31:0]        rd_tlp_cnt_o,
    output logic [31:0]        stall_cnt_o
`endif
);

    tlp_arb_state_t        state_q;
    tlp_arb_state_t        state_d;

    logic                  wr_req;
    logic                  rd_req;
    logic                  gnt_en;
    logic                  gnt_vld;
    tlp_src_t              gnt_src;

    logic                  beat_vld;
    logic [DATA_WIDTH-1:0] beat_dat;
    logic                  beat_sop;
    logic                  beat_eop;
    logic                  beat_is_wr;
    logic                  aw_pop;
    logic                  ar_pop;
    logic                  pw_pop;

    // A write is only eligible once its first payload beat is already staged,
    // so the header is never sent ahead of data that might not exist.
    assign wr_req = !bus.aw_empty_i && !bus.pw_empty_i;
    assign rd_req = !bus.ar_empty_i;
    assign gnt_en = (state_q == IDLE);

    tlp_tx_arbiter_rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .rst      (rst),
        .req_wr   (wr_req),
        .req_rd   (rd_req),
        .grant_en (gnt_en),
        .gnt_vld  (gnt_vld),
        .gnt_src  (gnt_src)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_vld   = 1'b0;
        beat_dat   = '0;
        beat_sop   = 1'b0;
        beat_eop   = 1'b0;
        beat_is_wr = 1'b0;
        aw_pop     = 1'b0;
        ar_pop     = 1'b0;
        pw_pop     = 1'b0;

        case (state_q)
            IDLE: begin
                // The grant is held in the state itself; the cycle spent
                // here is the inter-TLP bubble.
                if (gnt_vld) begin
                    state_d = (gnt_src == SRC_WR) ? WR_HDR : RD_HDR;
                end
            end

            WR_HDR: begin
                beat_vld                = 1'b1;
                beat_dat[HDR_WIDTH-1:0] = bus.aw_rdata_i;
                beat_sop                = 1'b1;
                beat_is_wr              = 1'b1;
                if (bus.tlp_ready_i) begin
                    aw_pop  = 1'b1;
                    state_d = WR_DATA;
                end
            end

            WR_DATA: begin
                // A payload underrun just drops valid; the write TLP keeps
                // ownership of the stream until its last beat goes out.
                beat_vld   = !bus.pw_empty_i;
                beat_dat   = bus.pw_rdata_i;
                beat_eop   = !bus.pw_empty_i && bus.pw_last_i;
                beat_is_wr = 1'b1;
                if (beat_vld && bus.tlp_ready_i) begin
                    pw_pop = 1'b1;
                    if (bus.pw_last_i) begin
                        state_d = IDLE;
                    end
                end
            end

            RD_HDR: begin
                beat_vld                = 1'b1;
                beat_dat[HDR_WIDTH-1:0] = bus.ar_rdata_i;
                beat_sop                = 1'b1;
                beat_eop                = 1'b1;
                if (bus.tlp_ready_i) begin
                    ar_pop  = 1'b1;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Reset silences the stream and the pops in the same cycle it is
        // asserted, not only after the state register clears.
        if (rst) begin
            beat_vld   = 1'b0;
            beat_dat   = '0;
            beat_sop   = 1'b0;
            beat_eop   = 1'b0;
            beat_is_wr = 1'b0;
            aw_pop     = 1'b0;
            ar_pop     = 1'b0;
            pw_pop     = 1'b0;
        end
    end

    assign bus.tlp_valid_o = beat_vld;
    assign bus.tlp_data_o  = beat_dat;
    assign bus.tlp_sop_o   = beat_sop;
    assign bus.tlp_eop_o   = beat_eop;
    assign bus.tlp_is_wr_o = beat_is_wr;
    assign bus.aw_rden_o   = aw_pop;
    assign bus.ar_rden_o   = ar_pop;
    assign bus.pw_rden_o   = pw_pop;

`ifdef TLP_ARB_STATS_EN
    logic [31:0] wr_cnt_q;
    logic [31:0] rd_cnt_q;
    logic [31:0] stall_cnt_q;

    // All three counters wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (beat_vld && bus.tlp_ready_i && beat_is_wr && beat_eop) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end
            if (beat_vld && bus.tlp_ready_i && (state_q == RD_HDR)) begin
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end
            if (beat_vld && !bus.tlp_ready_i) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign wr_tlp_cnt_o = wr_cnt_q;
    assign rd_tlp_cnt_o = rd_cnt_q;
    assign stall_cnt_o  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_tlp_tx_arbiter.sv
// Self-checking bench for tlp_tx_arbiter: FIFO contents are held in queues,
// the expected beat stream is derived from the round-robin ordering rule,
// and every cycle's valid/rden/beat outputs are checked against it.
module tb_tlp_tx_arbiter;

    localparam int HW = 128;
    localparam int DW = 256;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic          is_wr;
    } beat_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } pw_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    tlp_tx_arbiter_if #(.HDR_WIDTH(HW), .DATA_WIDTH(DW)) bus ();

`ifdef TLP_ARB_STATS_EN
    logic [31:0] wr_cnt;
    logic [31:0] rd_cnt;
    logic [31:0] stall_cnt;
`endif

    tlp_tx_arbiter #(.HDR_WIDTH(HW), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus)
`ifdef TLP_ARB_STATS_EN
        ,
        .wr_tlp_cnt_o (wr_cnt),
        .rd_tlp_cnt_o (rd_cnt),
        .stall_cnt_o  (stall_cnt)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;

    // FIFO contents seen by the DUT
    logic [HW-1:0] aw_q[$];
    logic [HW-1:0] ar_q[$];
    pw_t           pw_q[$];
    pw_t           late_pw[$];
    // TLPs as offered, used to derive the expected stream
    logic [HW-1:0] wr_hdrs[$];
    int            wr_lens[$];
    logic [DW-1:0] pw_shadow[$];
    logic [HW-1:0] rd_hdrs[$];
    beat_t         exp_q[$];

    bit idle_next;
    int cyc;
    int late_at;
    int ready_pct;
    int hdr_stall;
    int n_wr_done;
    int n_rd_done;
    int n_stall;

    task automatic chk(input string tag, input logic [263:0] obs, input logic [263:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] zext(input logic [HW-1:0] h);
        logic [DW-1:0] r;
        r = '0;
        r[HW-1:0] = h;
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [HW-1:0] rand_hdr();
        logic [HW-1:0] r;
        for (int i = 0; i < HW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic clear_model();
        aw_q.delete(); ar_q.delete(); pw_q.delete(); late_pw.delete();
        wr_hdrs.delete(); wr_lens.delete(); pw_shadow.delete();
        rd_hdrs.delete(); exp_q.delete();
        idle_next = 1'b1;
        cyc       = 0;
        late_at   = -1;
        hdr_stall = 0;
        n_wr_done = 0;
        n_rd_done = 0;
        n_stall   = 0;
    endtask

    task automatic drive_inputs();
        bus.aw_empty_i = (aw_q.size() == 0);
        bus.aw_rdata_i = (aw_q.size() != 0) ? aw_q[0] : '0;
        bus.ar_empty_i = (ar_q.size() == 0);
        bus.ar_rdata_i = (ar_q.size() != 0) ? ar_q[0] : '0;
        bus.pw_empty_i = (pw_q.size() == 0);
        bus.pw_rdata_i = (pw_q.size() != 0) ? pw_q[0].data : '0;
        bus.pw_last_i  = (pw_q.size() != 0) ? pw_q[0].last : 1'b0;
    endtask

    // Leaves the bench at a negedge with reset released and empty FIFOs.
    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        clear_model();
        drive_inputs();
        bus.tlp_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // n_now payload beats are staged immediately, the rest appear at late_at.
    task automatic add_wr(input logic [HW-1:0] h, input int n, input int n_now);
        pw_t e;
        aw_q.push_back(h);
        wr_hdrs.push_back(h);
        wr_lens.push_back(n);
        for (int k = 0; k < n; k++) begin
            e.data = rand_data();
            e.last = (k == n - 1);
            pw_shadow.push_back(e.data);
            if (k < n_now) pw_q.push_back(e);
            else           late_pw.push_back(e);
        end
    endtask

    task automatic add_rd(input logic [HW-1:0] h);
        ar_q.push_back(h);
        rd_hdrs.push_back(h);
    endtask

    // Writes and reads alternate starting with a write; once one kind runs
    // out, the remaining TLPs of the other kind follow back to back.
    task automatic build_expected();
        int    wi;
        int    ri;
        int    pi;
        bit    turn_wr;
        beat_t b;
        wi = 0; ri = 0; pi = 0; turn_wr = 1'b1;
        exp_q.delete();
        while (wi < wr_hdrs.size() || ri < rd_hdrs.size()) begin
            if (wi < wr_hdrs.size() && (turn_wr || ri >= rd_hdrs.size())) begin
                b.data = zext(wr_hdrs[wi]); b.sop = 1'b1; b.eop = 1'b0; b.is_wr = 1'b1;
                exp_q.push_back(b);
                for (int k = 0; k < wr_lens[wi]; k++) begin
                    b.data = pw_shadow[pi]; pi++;
                    b.sop = 1'b0; b.eop = (k == wr_lens[wi] - 1); b.is_wr = 1'b1;
                    exp_q.push_back(b);
                end
                wi++;
                turn_wr = 1'b0;
            end else begin
                b.data = zext(rd_hdrs[ri]); b.sop = 1'b1; b.eop = 1'b1; b.is_wr = 1'b0;
                exp_q.push_back(b);
                ri++;
                turn_wr = 1'b1;
            end
        end
    endtask

    // One clock: called and returns at a negedge.
    task automatic cycle();
        bit    exp_vld;
        bit    acc;
        bit    head_hdr_wr;
        bit    head_rd;
        bit    head_pw;
        bit    req;
        beat_t obs;
        if (late_pw.size() != 0 && cyc == late_at)
            while (late_pw.size() != 0) pw_q.push_back(late_pw.pop_front());
        drive_inputs();
        exp_vld = 1'b0; head_hdr_wr = 1'b0; head_rd = 1'b0; head_pw = 1'b0;
        if (!idle_next && exp_q.size() != 0) begin
            head_hdr_wr = exp_q[0].sop && exp_q[0].is_wr;
            head_rd     = !exp_q[0].is_wr;
            head_pw     = !exp_q[0].sop;
            exp_vld     = head_pw ? (pw_q.size() != 0) : 1'b1;
        end
        if (hdr_stall > 0 && exp_vld && head_hdr_wr) begin
            bus.tlp_ready_i = 1'b0;
            hdr_stall--;
        end else begin
            bus.tlp_ready_i = ($urandom_range(0, 99) < ready_pct);
        end
        #1;
        acc = exp_vld && bus.tlp_ready_i;
        chk("valid",   264'(bus.tlp_valid_o), 264'(exp_vld));
        chk("aw_rden", 264'(bus.aw_rden_o),   264'(acc && head_hdr_wr));
        chk("ar_rden", 264'(bus.ar_rden_o),   264'(acc && head_rd));
        chk("pw_rden", 264'(bus.pw_rden_o),   264'(acc && head_pw));
        if (exp_vld) begin
            obs.data  = bus.tlp_data_o;
            obs.sop   = bus.tlp_sop_o;
            obs.eop   = bus.tlp_eop_o;
            obs.is_wr = bus.tlp_is_wr_o;
            chk("beat", 264'(obs), 264'(exp_q[0]));
            if (!bus.tlp_ready_i) n_stall++;
        end
        @(posedge clk);
        if (acc) begin
            if (head_hdr_wr) void'(aw_q.pop_front());
            if (head_rd)     void'(ar_q.pop_front());
            if (head_pw)     void'(pw_q.pop_front());
            if (exp_q[0].eop) begin
                idle_next = 1'b1;
                if (exp_q[0].is_wr) n_wr_done++;
                else                n_rd_done++;
            end
            void'(exp_q.pop_front());
        end else if (idle_next && exp_q.size() != 0) begin
            req = exp_q[0].is_wr ? (aw_q.size() != 0 && pw_q.size() != 0)
                                 : (ar_q.size() != 0);
            if (req) idle_next = 1'b0;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic check_counters(input string name);
`ifdef TLP_ARB_STATS_EN
        chk({name, " wr_cnt"},    264'(wr_cnt),    264'(n_wr_done));
        chk({name, " rd_cnt"},    264'(rd_cnt),    264'(n_rd_done));
        chk({name, " stall_cnt"}, 264'(stall_cnt), 264'(n_stall));
`else
        chk({name, " tlp_count"}, 264'(n_wr_done + n_rd_done),
            264'(wr_hdrs.size() + rd_hdrs.size()));
`endif
    endtask

    task automatic run(input string name, input int budget);
        int n;
        n = 0;
        build_expected();
        while (exp_q.size() != 0 && n < budget) begin
            cycle();
            n++;
        end
        chk({name, " drained"}, 264'(exp_q.size()), 264'(0));
        cycle();  // trailing bubble: nothing left to send
        check_counters(name);
    endtask

    task automatic check_all_zero(input string name);
        chk({name, " valid"}, 264'(bus.tlp_valid_o), 264'(0));
        chk({name, " data"},  264'(bus.tlp_data_o),  264'(0));
        chk({name, " flags"}, 264'({bus.tlp_sop_o, bus.tlp_eop_o, bus.tlp_is_wr_o}), 264'(0));
        chk({name, " rden"},  264'({bus.aw_rden_o, bus.ar_rden_o, bus.pw_rden_o}), 264'(0));
    endtask

    initial begin
        logic [HW-1:0] a5;
        int            nw;
        int            nr;
        clear_model();
        bus.tlp_ready_i = 1'b0;
        drive_inputs();
        ready_pct = 100;

        reset_dut();
        #1;
        check_all_zero("post_reset");
`ifdef TLP_ARB_STATS_EN
        chk("post_reset counters", 264'({wr_cnt, rd_cnt, stall_cnt}), 264'(0));
`endif

        // Single read with an A5 pattern header
        reset_dut();
        a5 = {16{8'hA5}};
        add_rd(a5);
        run("single_rd", 20);

        // Single write: header plus three payload beats, ready held high
        reset_dut();
        add_wr(rand_hdr(), 3, 3);
        run("single_wr", 20);

        // Two one-beat writes and two reads queued together
        reset_dut();
        add_wr(rand_hdr(), 1, 1);
        add_wr(rand_hdr(), 1, 1);
        add_rd(rand_hdr());
        add_rd(rand_hdr());
        run("contention", 40);

        // Header beat held for five cycles of backpressure
        reset_dut();
        hdr_stall = 5;
        add_wr(rand_hdr(), 2, 2);
        run("backpressure", 30);

        // Payload underrun after D0 with a read pending behind the write
        reset_dut();
        add_wr(rand_hdr(), 3, 1);
        add_rd(rand_hdr());
        late_at = 6;
        run("underrun", 40);

        // Reset in the middle of a write payload
        reset_dut();
        add_wr(rand_hdr(), 3, 3);
        build_expected();
        repeat (3) cycle();  // bubble, header, D0
        rst = 1'b1;
        drive_inputs();
        #1;
        chk("rst_now valid", 264'(bus.tlp_valid_o), 264'(0));
        chk("rst_now rden",  264'({bus.aw_rden_o, bus.ar_rden_o, bus.pw_rden_o}), 264'(0));
        @(negedge clk);
        rst = 1'b0;
        clear_model();  // upstream FIFOs share the reset
        drive_inputs();
        bus.tlp_ready_i = 1'b1;
        #1;
        check_all_zero("after_rst");
`ifdef TLP_ARB_STATS_EN
        chk("after_rst counters", 264'({wr_cnt, rd_cnt, stall_cnt}), 264'(0));
`endif
        @(negedge clk);
        add_rd(rand_hdr());
        run("post_rst_rd", 20);

        // Randomized mixes with random backpressure
        for (int r = 0; r < 8; r++) begin
            reset_dut();
            ready_pct = $urandom_range(30, 100);
            nw = $urandom_range(0, 5);
            nr = $urandom_range(0, 5);
            for (int i = 0; i < nw; i++) begin
                int len;
                len = $urandom_range(1, 4);
                add_wr(rand_hdr(), len, len);
            end
            for (int i = 0; i < nr; i++) add_rd(rand_hdr());
            run("random", 600);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tlp_tx_arbiter.md
Name: tlp_tx_arbiter

Overview:
- Sequences the three TX staging FIFOs (AW header, AR header, write payload) into a single TLP beat stream toward the future TLP framing/PIPE stage.
- Arbitrates round-robin between memory-write TLPs (header plus payload beats) and memory-read TLPs (header only).
- Drives each FIFO's rden and never interleaves beats of different TLPs.
- Sits directly after the three SAL_FIFO instances in the PCIe top wrapper.

Parameters:
- HDR_WIDTH, 128, header FIFO entry width (one 4DW TLP header).
- DATA_WIDTH, PCIE_PKG::PIPE_DATA_WIDTH, payload FIFO entry width and output beat width; must be >= HDR_WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- aw_empty_i  in  1  AW header FIFO empty
- aw_rdata_i  in  HDR_WIDTH  AW FIFO head entry
- aw_rden_o  out  1  pop AW FIFO
- ar_empty_i  in  1  AR header FIFO empty
- ar_rdata_i  in  HDR_WIDTH  AR FIFO head entry
- ar_rden_o  out  1  pop AR FIFO
- pw_empty_i  in  1  payload FIFO empty
- pw_rdata_i  in  DATA_WIDTH  payload FIFO head
- pw_last_i  in  1  head payload beat is last of its TLP
- pw_rden_o  out  1  pop payload FIFO
- tlp_valid_o  out  1  beat valid
- tlp_ready_i  in  1  downstream accepts beat
- tlp_data_o  out  DATA_WIDTH  beat data
- tlp_sop_o  out  1  first beat of TLP
- tlp_eop_o  out  1  last beat of TLP
- tlp_is_wr_o  out  1  current TLP is a write; valid with tlp_valid_o

Behaviour:
- FIFOs are show-ahead: rdata is valid whenever empty=0, and rden pops the head in the same cycle. Every rden equals (corresponding beat valid) & tlp_ready_i; a FIFO is never popped while empty.
- States: IDLE, WR_HDR, WR_DATA, RD_HDR. Reset gives state=IDLE and last_grant=RD, so WR wins the first tie.
- IDLE:
  - wr_req = !aw_empty & !pw_empty; rd_req = !ar_empty.
  - If both requests are active, grant the side opposite last_grant. Otherwise grant the single requester.
  - Register the grant and update last_grant. Next state is WR_HDR or RD_HDR. tlp_valid_o=0 in IDLE, giving one bubble cycle per TLP.
- WR_HDR:
  - tlp_valid_o=1; tlp_data_o = header zero-extended to DATA_WIDTH; sop=1, eop=0, is_wr=1.
  - On ready: pop AW, go to WR_DATA.
- WR_DATA:
  - tlp_valid_o = !pw_empty_i; data=pw_rdata_i; sop=0; eop=pw_last_i; is_wr=1.
  - On valid&ready: pop payload. If pw_last_i=1, go to IDLE.
  - Payload underrun mid-TLP: valid drops and the block stays in WR_DATA. Reads are not serviced until the write TLP completes.
- RD_HDR:
  - valid=1; data = AR header zero-extended; sop=1, eop=1, is_wr=0.
  - On ready: pop AR, go to IDLE.
- Held beat: while valid=1 and ready=0, data/sop/eop/is_wr stay stable and no rden is asserted.
- Reset mid-TLP: returns to IDLE immediately with all rden/valid low. Partial TLP loss is acceptable; upstream FIFOs are reset by the same reset.
- Reset values: all outputs 0.

Optional Feature:
- Macro TLP_ARB_STATS_EN.
- When defined, adds output ports:
  - wr_tlp_cnt_o, 32-bit: increments on each write eop handshake.
  - rd_tlp_cnt_o, 32-bit: increments on each RD_HDR handshake.
  - stall_cnt_o, 32-bit: increments each cycle with valid&!ready.
- All three counters wrap at 2^32 and clear on rst.
- When not defined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- PCIE_PKG gets:
  - typedef tlp_arb_state_t enum {IDLE, WR_HDR, WR_DATA, RD_HDR}.
  - typedef tlp_src_t enum {SRC_WR, SRC_RD}.
  - localparam TLP_HDR_WIDTH=128.
- One sub-module, rr_arb2: a 2-requester round-robin with last-grant register and a grant-enable input.

Test Plan:
- Single read: AR gets header 0xA5.., others empty. Expect 1 IDLE cycle, then one beat with sop=eop=1, is_wr=0, data=0xA5.. zero-extended, and ar_rden for 1 cycle.
- Single write: AW header H, payload beats D0, D1, D2 with last on D2, ready=1. Expect beats H(sop), D0, D1, D2(eop), 4 consecutive cycles, and is_wr=1 throughout.
- Contention: 2 writes (1 beat each) and 2 reads queued at reset. Grant order is WR, RD, WR, RD.
- Backpressure: ready=0 for 5 cycles on the write header beat. tlp_data_o stays stable and no rden is asserted; the beat completes the cycle ready rises.
- Underrun: payload FIFO empties after D0 of a 3-beat write while a read is pending. valid=0 until D1 arrives, the read is not issued before eop, then the read follows.
- Reset mid-TLP: assert rst during WR_DATA. Next cycle all outputs are 0 and state is IDLE; with TLP_ARB_STATS_EN, counters read 0.
